// File: rtl/trap_controller.sv
// trap_controller: arbitrates exceptions, interrupts and xRET, sequences the
// CSR-file context switch (CS strobe, cause/epc/privilege) and the fetch redirect.
// Latency: event in cycle t -> CS at t+1 -> REDIRECT at t+2+REDIRECT_LAT (xRET: REDIRECT at t+1+REDIRECT_LAT).
// Backpressure: STALL holds fetch/decode from event acceptance through REDIR; new events are ignored until IDLE.
//
// Ports:
//   CLK, RST (sync, active-high)
//   IRQ_PENDING/IRQ_ENABLE/GLOBAL_IE/INSTR_BOUNDARY : interrupt inputs
//   EXC_VALID/EXC_CODE, RET_VALID/STATUS_XPP         : execute-stage events
//   PC_CUR, NPC_IN                                   : PCs saved into xepc
//   MEDELEG/MIDELEG                                  : delegation masks (TRAP_DELEG_EN only)
//   CS/NEW_PRIVILEGE/CAUSE/NPC                       : to csr_file
//   STALL/FLUSH/REDIRECT                             : to pipeline / fetch
//   PRIV                                             : shadow of current privilege
// Optional feature macro: TRAP_DELEG_EN (trap delegation to supervisor).

module trap_controller #(
  parameter int XLEN         = 64,
  parameter int IRQ_W        = 16,
  parameter int REDIRECT_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IRQ_W-1:0] IRQ_PENDING,
  input  logic [IRQ_W-1:0] IRQ_ENABLE,
  input  logic             GLOBAL_IE,
  input  logic             INSTR_BOUNDARY,
  input  logic             EXC_VALID,
  input  logic [5:0]       EXC_CODE,
  input  logic             RET_VALID,
  input  logic [1:0]       STATUS_XPP,
  input  logic [XLEN-1:0]  PC_CUR,
  input  logic [XLEN-1:0]  NPC_IN,
  input  logic [IRQ_W-1:0] MEDELEG,
  input  logic [IRQ_W-1:0] MIDELEG,
  output logic             CS,
  output logic [1:0]       NEW_PRIVILEGE,
  output logic [XLEN-1:0]  CAUSE,
  output logic [XLEN-1:0]  NPC,
  output logic             STALL,
  output logic             FLUSH,
  output logic             REDIRECT,
  output logic [1:0]       PRIV
);

  typedef enum logic [1:0] {IDLE, SWITCH, WAIT, REDIR} state_t;

  localparam logic [1:0] LAT_M1  = 2'(REDIRECT_LAT - 1);
  localparam logic [1:0] PRIV_M  = 2'b11;

  state_t           state;
  logic [1:0]       wait_cnt;

  logic [IRQ_W-1:0] irq_act;
  logic             irq_hit;
  logic [3:0]       irq_cause;
  logic [1:0]       irq_target;
  logic [1:0]       exc_target;
  logic             irq_take;
  logic             idle;
  logic             take_exc;
  logic             take_irq;
  logic             take_ret;

  assign irq_act = IRQ_PENDING & IRQ_ENABLE;

  // Fixed priority among the supported causes; every other bit is ignored.
  always_comb begin
    irq_hit   = 1'b1;
    irq_cause = 4'd0;
    if      (irq_act[11]) irq_cause = 4'd11;
    else if (irq_act[3])  irq_cause = 4'd3;
    else if (irq_act[7])  irq_cause = 4'd7;
    else if (irq_act[9])  irq_cause = 4'd9;
    else if (irq_act[1])  irq_cause = 4'd1;
    else if (irq_act[5])  irq_cause = 4'd5;
    else                  irq_hit   = 1'b0;
  end

`ifdef TRAP_DELEG_EN
  logic             exc_deleg;
  logic             irq_deleg;
  logic [IRQ_W-1:0] one_hot_base;

  assign one_hot_base = {{(IRQ_W-1){1'b0}}, 1'b1};
  // Shifting past the mask width yields zero, so codes >= IRQ_W never delegate.
  assign exc_deleg  = |(MEDELEG & (one_hot_base << EXC_CODE));
  assign irq_deleg  = |(MIDELEG & (one_hot_base << irq_cause));
  assign exc_target = (PRIV != PRIV_M && exc_deleg) ? 2'b01 : PRIV_M;
  assign irq_target = (PRIV != PRIV_M && irq_deleg) ? 2'b01 : PRIV_M;
`else
  logic unused_deleg;
  assign unused_deleg = ^{MEDELEG, MIDELEG};
  assign exc_target   = PRIV_M;
  assign irq_target   = PRIV_M;
`endif

  // Only a handful of interrupt bits take part in arbitration.
  logic unused_irq_bits;
  assign unused_irq_bits = ^irq_act;

  assign irq_take = irq_hit && INSTR_BOUNDARY && (GLOBAL_IE || (PRIV < irq_target));

  // Exception > xRET > interrupt.
  assign idle     = (state == IDLE);
  assign take_exc = idle && EXC_VALID;
  assign take_ret = idle && !EXC_VALID && RET_VALID;
  assign take_irq = idle && !EXC_VALID && !RET_VALID && irq_take;

  // Combinational so the pipeline freezes and kills in the acceptance cycle itself.
  assign STALL = !RST && (take_exc || take_irq || take_ret || !idle);
  assign FLUSH = !RST && (take_exc || take_irq);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      wait_cnt      <= 2'd0;
      CS            <= 1'b0;
      NEW_PRIVILEGE <= 2'b00;
      CAUSE         <= '0;
      NPC           <= '0;
      REDIRECT      <= 1'b0;
      PRIV          <= PRIV_M;
    end else begin
      CS       <= 1'b0;
      REDIRECT <= 1'b0;
      case (state)
        IDLE: begin
          if (take_exc) begin
            CAUSE         <= {{(XLEN-6){1'b0}}, EXC_CODE};
            NPC           <= PC_CUR;
            NEW_PRIVILEGE <= exc_target;
            CS            <= 1'b1;
            state         <= SWITCH;
          end else if (take_ret) begin
            PRIV     <= STATUS_XPP;
            wait_cnt <= 2'd0;
            state    <= WAIT;
          end else if (take_irq) begin
            CAUSE         <= {1'b1, {(XLEN-5){1'b0}}, irq_cause};
            NPC           <= NPC_IN;
            NEW_PRIVILEGE <= irq_target;
            CS            <= 1'b1;
            state         <= SWITCH;
          end
        end
        SWITCH: begin
          PRIV     <= NEW_PRIVILEGE;
          wait_cnt <= 2'd0;
          state    <= WAIT;
        end
        WAIT: begin
          // PC_OUT of the CSR file settles REDIRECT_LAT cycles after the switch.
          if (wait_cnt == LAT_M1) begin
            REDIRECT <= 1'b1;
            state    <= REDIR;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        REDIR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed stimulus pushes expected CS and REDIRECT
// events into queues; an independent monitor pops and compares them whenever
// the DUT strobes CS or REDIRECT. REDIRECT_LAT is left at its default of 1.

module tb_trap_controller;

  localparam int XLEN  = 64;
  localparam int IRQ_W = 16;

  logic             CLK;
  logic             RST;
  logic [IRQ_W-1:0] IRQ_PENDING;
  logic [IRQ_W-1:0] IRQ_ENABLE;
  logic             GLOBAL_IE;
  logic             INSTR_BOUNDARY;
  logic             EXC_VALID;
  logic [5:0]       EXC_CODE;
  logic             RET_VALID;
  logic [1:0]       STATUS_XPP;
  logic [XLEN-1:0]  PC_CUR;
  logic [XLEN-1:0]  NPC_IN;
  logic [IRQ_W-1:0] MEDELEG;
  logic [IRQ_W-1:0] MIDELEG;
  logic             CS;
  logic [1:0]       NEW_PRIVILEGE;
  logic [XLEN-1:0]  CAUSE;
  logic [XLEN-1:0]  NPC;
  logic             STALL;
  logic             FLUSH;
  logic             REDIRECT;
  logic [1:0]       PRIV;

  trap_controller dut (
    .CLK(CLK), .RST(RST),
    .IRQ_PENDING(IRQ_PENDING), .IRQ_ENABLE(IRQ_ENABLE),
    .GLOBAL_IE(GLOBAL_IE), .INSTR_BOUNDARY(INSTR_BOUNDARY),
    .EXC_VALID(EXC_VALID), .EXC_CODE(EXC_CODE),
    .RET_VALID(RET_VALID), .STATUS_XPP(STATUS_XPP),
    .PC_CUR(PC_CUR), .NPC_IN(NPC_IN),
    .MEDELEG(MEDELEG), .MIDELEG(MIDELEG),
    .CS(CS), .NEW_PRIVILEGE(NEW_PRIVILEGE), .CAUSE(CAUSE), .NPC(NPC),
    .STALL(STALL), .FLUSH(FLUSH), .REDIRECT(REDIRECT), .PRIV(PRIV)
  );

  typedef struct {
    int          cyc;
    logic [63:0] cause;
    logic [63:0] npc;
    logic [1:0]  np;
  } cs_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] priv;
  } rd_exp_t;

  cs_exp_t cs_q[$];
  rd_exp_t rd_q[$];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int t;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_cs(input int c, input logic [63:0] ca, input logic [63:0] pc, input logic [1:0] np);
    cs_exp_t e;
    e.cyc = c; e.cause = ca; e.npc = pc; e.np = np;
    cs_q.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [1:0] p);
    rd_exp_t e;
    e.cyc = c; e.priv = p;
    rd_q.push_back(e);
  endtask

  // Advance to just after the next rising edge; inputs set now apply to this new cycle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares every CS / REDIRECT strobe against the scoreboard.
  always @(negedge CLK) begin
    cs_exp_t ce;
    rd_exp_t re;
    if (CS === 1'b1 && REDIRECT === 1'b1) begin
      nvec++; nerr++;
      $display("FAIL cs_redirect_overlap: both strobes high at cycle %0d, required never together", cyc);
    end
    if (CS === 1'b1) begin
      if (cs_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_cs: CS=1 at cycle %0d, required 0", cyc);
      end else begin
        ce = cs_q.pop_front();
        chk("cs_cycle", 64'(cyc), 64'(ce.cyc));
        chk("cs_cause", CAUSE, ce.cause);
        chk("cs_npc", NPC, ce.npc);
        chk("cs_new_priv", 64'(NEW_PRIVILEGE), 64'(ce.np));
      end
    end
    if (REDIRECT === 1'b1) begin
      if (rd_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_redirect: REDIRECT=1 at cycle %0d, required 0", cyc);
      end else begin
        re = rd_q.pop_front();
        chk("redir_cycle", 64'(cyc), 64'(re.cyc));
        chk("redir_priv", 64'(PRIV), 64'(re.priv));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    IRQ_PENDING = '0; IRQ_ENABLE = '0; GLOBAL_IE = 1'b0; INSTR_BOUNDARY = 1'b1;
    EXC_VALID = 1'b0; EXC_CODE = '0; RET_VALID = 1'b0; STATUS_XPP = 2'b00;
    PC_CUR = '0; NPC_IN = '0; MEDELEG = '0; MIDELEG = '0;
    steps(2);
    RST = 1'b0;

    // Reset state after 5 idle cycles.
    steps(5);
    @(negedge CLK);
    chk("rst_priv", 64'(PRIV), 64'd3);
    chk("rst_cs", 64'(CS), 64'd0);
    chk("rst_stall", 64'(STALL), 64'd0);
    chk("rst_flush", 64'(FLUSH), 64'd0);
    chk("rst_redirect", 64'(REDIRECT), 64'd0);
    chk("rst_cause", CAUSE, 64'd0);

    // Synchronous exception, code 2.
    step();
    EXC_VALID = 1'b1; EXC_CODE = 6'd2; PC_CUR = 64'h1000;
    t = cyc;
    push_cs(t + 1, 64'h2, 64'h1000, 2'd3);
    push_rd(t + 3, 2'd3);
    @(negedge CLK);
    chk("exc_stall_t", 64'(STALL), 64'd1);
    chk("exc_flush_t", 64'(FLUSH), 64'd1);
    step();
    EXC_VALID = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      chk("exc_stall_hold", 64'(STALL), 64'd1);
      chk("exc_flush_once", 64'(FLUSH), 64'd0);
      step();
    end
    @(negedge CLK);
    chk("exc_stall_release", 64'(STALL), 64'd0);

    // Interrupts 11 and 7 pending: 11 wins.
    step();
    IRQ_PENDING = 16'h0880; IRQ_ENABLE = 16'h0880; GLOBAL_IE = 1'b1;
    INSTR_BOUNDARY = 1'b1; NPC_IN = 64'h2004;
    t = cyc;
    push_cs(t + 1, 64'h8000_0000_0000_000B, 64'h2004, 2'd3);
    push_rd(t + 3, 2'd3);
    @(negedge CLK);
    chk("irq_flush", 64'(FLUSH), 64'd1);
    step();
    IRQ_PENDING = '0;
    steps(3);
    @(negedge CLK);
    chk("irq_cause_hold", CAUSE, 64'h8000_0000_0000_000B);

    // Same interrupt off an instruction boundary: not taken.
    step();
    IRQ_PENDING = 16'h0880; INSTR_BOUNDARY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("irq_no_boundary_stall", 64'(STALL), 64'd0);
      step();
    end
    IRQ_PENDING = '0; INSTR_BOUNDARY = 1'b1;

    // Machine mode with GLOBAL_IE=0: not taken.
    IRQ_PENDING = 16'h0800; GLOBAL_IE = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("irq_masked_stall", 64'(STALL), 64'd0);
      step();
    end
    IRQ_PENDING = '0; GLOBAL_IE = 1'b1;

    // Exception and interrupt 7 together: exception first, interrupt after REDIR.
    step();
    EXC_VALID = 1'b1; EXC_CODE = 6'd2; PC_CUR = 64'h3000;
    IRQ_PENDING = 16'h0080; IRQ_ENABLE = 16'h0080; NPC_IN = 64'h3004;
    t = cyc;
    push_cs(t + 1, 64'h2, 64'h3000, 2'd3);
    push_rd(t + 3, 2'd3);
    push_cs(t + 5, 64'h8000_0000_0000_0007, 64'h3004, 2'd3);
    push_rd(t + 7, 2'd3);
    step();
    EXC_VALID = 1'b0;
    steps(3);
    @(negedge CLK);
    chk("simul_irq_flush", 64'(FLUSH), 64'd1);
    step();
    IRQ_PENDING = '0;
    steps(3);

    // xRET from machine to user.
    step();
    RET_VALID = 1'b1; STATUS_XPP = 2'b00;
    t = cyc;
    push_rd(t + 2, 2'd0);
    @(negedge CLK);
    chk("ret_stall", 64'(STALL), 64'd1);
    chk("ret_no_flush", 64'(FLUSH), 64'd0);
    step();
    RET_VALID = 1'b0;
    @(negedge CLK);
    chk("ret_priv", 64'(PRIV), 64'd0);
    steps(2);

`ifdef TRAP_DELEG_EN
    // Delegated exception from user mode lands in supervisor.
    step();
    MEDELEG = 16'h0100; EXC_VALID = 1'b1; EXC_CODE = 6'd8; PC_CUR = 64'h4000;
    t = cyc;
    push_cs(t + 1, 64'h8, 64'h4000, 2'd1);
    push_rd(t + 3, 2'd1);
    step();
    EXC_VALID = 1'b0;
    steps(3);
`endif

    // Below machine mode an interrupt is taken even with GLOBAL_IE=0; 3 beats 7.
    step();
    IRQ_PENDING = 16'h0088; IRQ_ENABLE = 16'h0088; GLOBAL_IE = 1'b0; NPC_IN = 64'h5000;
    t = cyc;
    push_cs(t + 1, 64'h8000_0000_0000_0003, 64'h5000, 2'd3);
    push_rd(t + 3, 2'd3);
    step();
    IRQ_PENDING = '0; GLOBAL_IE = 1'b1;
    steps(3);

`ifdef TRAP_DELEG_EN
    // Same delegated code from machine mode stays in machine mode.
    step();
    EXC_VALID = 1'b1; EXC_CODE = 6'd8; PC_CUR = 64'h4000;
    t = cyc;
    push_cs(t + 1, 64'h8, 64'h4000, 2'd3);
    push_rd(t + 3, 2'd3);
    step();
    EXC_VALID = 1'b0; MEDELEG = '0;
    steps(3);
`endif

    // Reset during WAIT abandons the xRET redirect.
    step();
    RET_VALID = 1'b1; STATUS_XPP = 2'b00;
    step();
    RET_VALID = 1'b0; RST = 1'b1;
    @(negedge CLK);
    chk("rstwait_priv_before", 64'(PRIV), 64'd0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rstwait_priv", 64'(PRIV), 64'd3);
    chk("rstwait_redirect", 64'(REDIRECT), 64'd0);
    chk("rstwait_stall", 64'(STALL), 64'd0);
    chk("rstwait_cause", CAUSE, 64'd0);
    steps(4);

    @(negedge CLK);
    chk("cs_queue_drained", 64'(cs_q.size()), 64'd0);
    chk("redir_queue_drained", 64'(rd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequences context switches into the CSR file: arbitrates pending interrupts against synchronous exceptions and xRET, and drives the CSR file's CS/NEW_PRIVILEGE/CAUSE/NPC inputs.
- Stalls and flushes the pipeline around each switch, then asserts the fetch redirect once the CSR file's registered PC_OUT is valid.
- Sits between the decode/execute stages and csr_file.

Parameters:
- XLEN, 64, data and PC width.
- IRQ_W, 16, width of the interrupt pending/enable vectors (RISC-V cause numbering).
- REDIRECT_LAT, 1, cycles from the CS/RET pulse until PC_OUT is valid (1 to 3).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- IRQ_PENDING  in  IRQ_W  level-sensitive interrupt lines (mip).
- IRQ_ENABLE  in  IRQ_W  per-cause enables (mie).
- GLOBAL_IE  in  1  current-privilege xstatus.xIE.
- INSTR_BOUNDARY  in  1  an instruction retires this cycle; interrupts are taken only here.
- EXC_VALID  in  1  synchronous exception from execute.
- EXC_CODE  in  6  exception cause code.
- RET_VALID  in  1  decoded xRET in execute.
- STATUS_XPP  in  2  xstatus.xPP of the current privilege.
- PC_CUR  in  XLEN  PC of the instruction in execute.
- NPC_IN  in  XLEN  PC of the next sequential instruction.
- MEDELEG  in  IRQ_W  exception delegation mask (used only with the optional feature).
- MIDELEG  in  IRQ_W  interrupt delegation mask (used only with the optional feature).
- CS  out  1  one-cycle context-switch strobe to the CSR file.
- NEW_PRIVILEGE  out  2  target privilege.
- CAUSE  out  XLEN  cause value written into xcause.
- NPC  out  XLEN  value saved into xepc.
- STALL  out  1  freezes fetch/decode.
- FLUSH  out  1  one-cycle kill of younger instructions.
- REDIRECT  out  1  one-cycle strobe: fetch loads the CSR file's PC_OUT.
- PRIV  out  2  shadow of the current privilege.

Behaviour:
- Reset values: all outputs 0 except PRIV=2'b11. FSM returns to IDLE. RST mid-switch abandons the switch, with no CS and no REDIRECT.
- FSM states: IDLE, SWITCH, WAIT, REDIR.
- IDLE, event selection, highest first:
  - EXC_VALID: CAUSE={0, zero-extended EXC_CODE}; NPC=PC_CUR.
  - An interrupt is eligible when IRQ_PENDING&IRQ_ENABLE is nonzero, GLOBAL_IE=1 or PRIV < target privilege, and INSTR_BOUNDARY=1.
    - Winning cause, fixed priority: 11 > 3 > 7 > 9 > 1 > 5. All other bits are ignored.
    - CAUSE={1 at bit XLEN-1, cause zero-extended}; NPC=NPC_IN.
  - RET_VALID: PRIV<=STATUS_XPP. No CS. Go to WAIT.
- Exception or interrupt selected: go to SWITCH. In the same cycle, register CAUSE and NPC, and assert STALL and FLUSH.
- SWITCH (1 cycle): CS=1; NEW_PRIVILEGE=target (2'b11 without delegation); PRIV<=target; go to WAIT.
- WAIT: count REDIRECT_LAT cycles, then go to REDIR.
- REDIR: REDIRECT=1 for 1 cycle; return to IDLE.
- STALL is held high from event acceptance through REDIR inclusive.
- Simultaneous events:
  - Exception beats interrupt. The interrupt remains pending (level) and is re-evaluated in IDLE.
  - Exception beats RET.
  - RET beats interrupt. The interrupt is taken at a later boundary.
- In SWITCH/WAIT/REDIR all new EXC_VALID/RET_VALID/IRQ inputs are ignored; the flushed pipeline regenerates them.
- CS and REDIRECT never assert in the same cycle. CAUSE and NPC hold their values until the next accepted event.
- Latency: exception at cycle t → CS at t+1 → REDIRECT at t+2+REDIRECT_LAT.

Optional Feature:
- Macro: TRAP_DELEG_EN.
- Defined: target = 2'b01 (supervisor) when PRIV != 2'b11 and the corresponding MEDELEG[EXC_CODE] bit (exception) or MIDELEG[cause] bit (interrupt) is 1; otherwise 2'b11. Exception codes ≥ IRQ_W are never delegated.
- Undefined: MEDELEG and MIDELEG are unused; every trap targets 2'b11.

Test Plan:
- Reset, then idle 5 cycles → PRIV=3, CS/STALL/FLUSH/REDIRECT=0.
- EXC_VALID=1, EXC_CODE=2, PC_CUR=0x1000 → CS at t+1, CAUSE=0x2, NPC=0x1000, NEW_PRIVILEGE=3, REDIRECT at t+3 (REDIRECT_LAT=1), STALL high t..t+3.
- IRQ_PENDING=IRQ_ENABLE=0x0880, GLOBAL_IE=1, INSTR_BOUNDARY=1, NPC_IN=0x2004 → CAUSE=0x800000000000000B, NPC=0x2004. Repeat with INSTR_BOUNDARY=0 → no CS.
- EXC_VALID and IRQ bit 7 in the same cycle → CAUSE=0x2 exception path. Interrupt taken after REDIR at the next boundary with CAUSE=0x8000000000000007.
- PRIV=3, RET_VALID=1, STATUS_XPP=0 → no CS, PRIV=0, REDIRECT after REDIRECT_LAT+1 cycles. Assert RST during WAIT → no REDIRECT, PRIV=3.
- With TRAP_DELEG_EN: PRIV=0, MEDELEG[8]=1, EXC_CODE=8 → NEW_PRIVILEGE=1. Same stimulus at PRIV=3 → NEW_PRIVILEGE=3.
